core_ctrl_fsm: RTL and testbench

- Multi-cycle control sequencer for the simple RV32I core.
- Consumes the instruction decoder's opcode, funct3 and rd fields. Drives the instruction-fetch and data-memory request/ready handshakes.
- Drives the IR, PC, register-file and ALU operand-select enables.
- Counts retired instructions and traps on illegal opcodes or memory timeouts.

---
 rtl/core_ctrl_fsm.sv | 197 +++++++++++++++++++
 tb/tb_core_ctrl_fsm.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : core_ctrl_fsm
// Brief    : Multi-cycle control sequencer for the RV32I core.
// Revision : 1.0 - initial release
// ============================================================================
module core_ctrl_fsm #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic [4:0]       rd,
    input  logic             branch_taken,
    output logic             imem_req,
    input  logic             imem_ready,
    output logic             ir_we,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ready,
    output logic             alu_src_a,
    output logic             alu_src_b,
    output logic             rf_we,
    output logic [1:0]       wb_sel,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             halted,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] instret,
    output logic [2:0]       state_o
);

    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_OP     = 7'b0110011;
    localparam logic [6:0] c_OP_OPIM   = 7'b0010011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_SYSTEM = 7'b1110011;

    localparam int               c_WAIT_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(MEM_TIMEOUT - 1);
    localparam bit               c_TIMEOUT_EN = (MEM_TIMEOUT != 0);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0]    r_instret;
    logic [1:0]          r_trap_cause;
    logic [1:0]          w_cause_nxt;

    logic w_is_load, w_is_store, w_is_op, w_is_opim, w_is_branch;
    logic w_is_jal, w_is_jalr, w_is_lui, w_is_auipc, w_is_system;
    logic w_legal, w_wait_expired;

    assign w_is_load   = (opcode == c_OP_LOAD);
    assign w_is_store  = (opcode == c_OP_STORE);
    assign w_is_op     = (opcode == c_OP_OP);
    assign w_is_opim   = (opcode == c_OP_OPIM);
    assign w_is_branch = (opcode == c_OP_BRANCH);
    assign w_is_jal    = (opcode == c_OP_JAL);
    assign w_is_jalr   = (opcode == c_OP_JALR);
    assign w_is_lui    = (opcode == c_OP_LUI);
    assign w_is_auipc  = (opcode == c_OP_AUIPC);
    assign w_is_system = (opcode == c_OP_SYSTEM);
    assign w_legal     = w_is_load | w_is_store | w_is_op | w_is_opim | w_is_branch |
                         w_is_jal | w_is_jalr | w_is_lui | w_is_auipc | w_is_system;

    // Ready arriving on the last allowed cycle is checked first, so it wins.
    assign w_wait_expired = c_TIMEOUT_EN && (r_wait_cnt == c_WAIT_LAST);

    always_comb begin
        w_next      = r_state;
        w_cause_nxt = 2'd0;
        imem_req    = 1'b0;
        ir_we       = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 1'b0;
        rf_we       = 1'b0;
        wb_sel      = 2'd0;
        pc_we       = 1'b0;
        pc_sel      = 2'd0;
        case (r_state)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_we  = 1'b1;
                    w_next = S_DECODE;
                end else if (w_wait_expired) begin
                    w_next      = S_TRAP;
                    w_cause_nxt = 2'd2;
                end
            end
            S_DECODE: begin
                if (!w_legal) begin
                    w_next      = S_TRAP;
                    w_cause_nxt = 2'd1;
                end else if (w_is_system) begin
                    w_next = (funct3 == 3'd0) ? S_HALT : S_WB;
                end else begin
                    w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_src_a = w_is_auipc | w_is_jal | w_is_branch;
                alu_src_b = ~(w_is_op | w_is_branch);
                if (w_is_branch) begin
                    pc_we  = 1'b1;
                    pc_sel = branch_taken ? 2'd1 : 2'd0;
                    w_next = S_FETCH;
                end else if (w_is_load | w_is_store) begin
                    w_next = S_MEM;
                end else begin
                    w_next = S_WB;
                end
            end
            S_MEM: begin
                dmem_req  = 1'b1;
                dmem_we   = w_is_store;
                alu_src_b = 1'b1;
                if (dmem_ready) begin
                    if (w_is_store) begin
                        pc_we  = 1'b1;
                        w_next = S_FETCH;
                    end else begin
                        w_next = S_WB;
                    end
                end else if (w_wait_expired) begin
                    w_next      = S_TRAP;
                    w_cause_nxt = 2'd2;
                end
            end
            S_WB: begin
                rf_we  = (rd != 5'd0) && !w_is_system;
                wb_sel = w_is_load ? 2'd1 :
                         (w_is_jal | w_is_jalr) ? 2'd2 :
                         w_is_lui ? 2'd3 : 2'd0;
                pc_sel = w_is_jal ? 2'd1 : w_is_jalr ? 2'd2 : 2'd0;
                pc_we  = 1'b1;
                w_next = S_FETCH;
            end
            S_HALT, S_TRAP: ;
            default: w_next = S_FETCH;
        endcase
        // Strobes must stay quiet while reset holds the state in FETCH.
        if (!rst_n) begin
            imem_req = 1'b0;
            ir_we    = 1'b0;
            pc_we    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_FETCH;
            r_wait_cnt   <= '0;
            r_instret    <= '0;
            r_trap_cause <= 2'd0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state)
                r_wait_cnt <= '0;
            else if ((r_state == S_FETCH) || (r_state == S_MEM))
                r_wait_cnt <= r_wait_cnt + c_WAIT_W'(1);
            if (pc_we)
                r_instret <= r_instret + CNT_W'(1);
            if ((w_next == S_TRAP) && (r_state != S_TRAP))
                r_trap_cause <= w_cause_nxt;
        end
    end

    assign halted     = (r_state == S_HALT);
    assign trap       = (r_state == S_TRAP);
    assign trap_cause = r_trap_cause;
    assign instret    = r_instret;
    assign state_o    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_core_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_core_ctrl_fsm
// Brief    : Instruction-level trace model and per-cycle compare for core_ctrl_fsm.
// Revision : 1.0 - initial release
// ============================================================================
module tb_core_ctrl_fsm;
    localparam int TO = 16;
    localparam int CW = 4;   // narrow counter so wrap-around is exercised

    localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011, OP = 7'b0110011,
                           OPIM = 7'b0010011, BRANCH = 7'b1100011, JAL = 7'b1101111,
                           JALR = 7'b1100111, LUI = 7'b0110111, AUIPC = 7'b0010111,
                           SYSTEM = 7'b1110011;

    logic clk = 1'b0;
    logic rst_n, imem_ready, dmem_ready, branch_taken;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic imem_req, ir_we, dmem_req, dmem_we, alu_src_a, alu_src_b, rf_we, pc_we;
    logic halted, trap;
    logic [1:0] wb_sel, pc_sel, trap_cause;
    logic [CW-1:0] instret;
    logic [2:0] state_o;

    always #5 clk = ~clk;

    core_ctrl_fsm #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .rd(rd),
        .branch_taken(branch_taken), .imem_req(imem_req), .imem_ready(imem_ready),
        .ir_we(ir_we), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .rf_we(rf_we), .wb_sel(wb_sel),
        .pc_we(pc_we), .pc_sel(pc_sel), .halted(halted), .trap(trap),
        .trap_cause(trap_cause), .instret(instret), .state_o(state_o)
    );

    // One expected cycle: inputs to apply plus the outputs they must produce.
    typedef struct packed {
        logic rst_n, imem_ready, dmem_ready, taken;
        logic [6:0] op; logic [2:0] f3; logic [4:0] rd;
        logic imem_req, ir_we, dmem_req, dmem_we, src_a, src_b, rf_we;
        logic [1:0] wb_sel; logic pc_we; logic [1:0] pc_sel;
        logic halted, trap; logic [1:0] cause;
        logic [CW-1:0] instret; logic [2:0] state;
    } cyc_t;

    cyc_t q[$];
    cyc_t cur;
    bit   cur_valid = 1'b0;
    int   n_checks = 0, n_fail = 0, dmem_cnt = 0;
    int   n_emit = 0, limit = 1 << 30;

    logic [CW-1:0] m_instret = '0;
    logic m_halted = 1'b0, m_trap = 1'b0;
    logic [1:0] m_cause = 2'd0;

    function automatic bit is_legal(logic [6:0] op);
        return op inside {LOAD, STORE, OP, OPIM, BRANCH, JAL, JALR, LUI, AUIPC, SYSTEM};
    endfunction

    function automatic cyc_t mk(logic [6:0] op, logic [2:0] f3, logic [4:0] r);
        cyc_t e = '0;
        e.rst_n = 1'b1; e.op = op; e.f3 = f3; e.rd = r;
        e.imem_ready = 1'($urandom); e.dmem_ready = 1'($urandom); e.taken = 1'($urandom);
        e.halted = m_halted; e.trap = m_trap; e.cause = m_cause; e.instret = m_instret;
        return e;
    endfunction

    task automatic emit(cyc_t e);
        if (n_emit < limit) q.push_back(e);
        n_emit++;
    endtask

    task automatic absorb(logic [2:0] st, logic [6:0] op, logic [2:0] f3, logic [4:0] r);
        cyc_t e;
        repeat (3) begin e = mk(op, f3, r); e.state = st; emit(e); end
    endtask

    task automatic gen_reset();
        cyc_t e;
        m_instret = '0; m_halted = 1'b0; m_trap = 1'b0; m_cause = 2'd0;
        limit = 1 << 30;
        e = mk(7'd0, 3'd0, 5'd0); e.rst_n = 1'b0;
        emit(e);
        n_emit = 0;
    endtask

    task automatic gen_fetch_idle();
        cyc_t e = mk(7'd0, 3'd0, 5'd0);
        e.imem_req = 1'b1; e.imem_ready = 1'b0;
        emit(e);
    endtask

    // Expected trace of one instruction starting from a fresh FETCH.
    task automatic gen_instr(logic [6:0] op, logic [2:0] f3, logic [4:0] r, int fw, int mw, logic tk);
        cyc_t e;
        int k = 0;
        while (1) begin
            e = mk(op, f3, r); e.state = 3'd0; e.imem_req = 1'b1;
            if (k == fw) begin e.imem_ready = 1'b1; e.ir_we = 1'b1; emit(e); break; end
            e.imem_ready = 1'b0; emit(e);
            if (k == TO - 1) begin m_trap = 1'b1; m_cause = 2'd2; absorb(3'd6, op, f3, r); return; end
            k++;
        end
        e = mk(op, f3, r); e.state = 3'd1; emit(e);
        if (!is_legal(op)) begin m_trap = 1'b1; m_cause = 2'd1; absorb(3'd6, op, f3, r); return; end
        if (op == SYSTEM && f3 == 3'd0) begin m_halted = 1'b1; absorb(3'd5, op, f3, r); return; end
        if (op != SYSTEM) begin
            e = mk(op, f3, r); e.state = 3'd2; e.taken = tk;
            e.src_a = (op == AUIPC || op == JAL || op == BRANCH);
            e.src_b = !(op == OP || op == BRANCH);
            if (op == BRANCH) begin
                e.pc_we = 1'b1; e.pc_sel = tk ? 2'd1 : 2'd0; emit(e);
                m_instret = m_instret + CW'(1); return;
            end
            emit(e);
            if (op == LOAD || op == STORE) begin
                k = 0;
                while (1) begin
                    e = mk(op, f3, r); e.state = 3'd3; e.dmem_req = 1'b1;
                    e.dmem_we = (op == STORE); e.src_b = 1'b1;
                    if (k == mw) begin
                        e.dmem_ready = 1'b1;
                        if (op == STORE) begin
                            e.pc_we = 1'b1; emit(e); m_instret = m_instret + CW'(1); return;
                        end
                        emit(e); break;
                    end
                    e.dmem_ready = 1'b0; emit(e);
                    if (k == TO - 1) begin m_trap = 1'b1; m_cause = 2'd2; absorb(3'd6, op, f3, r); return; end
                    k++;
                end
            end
        end
        e = mk(op, f3, r); e.state = 3'd4; e.pc_we = 1'b1;
        e.rf_we  = (r != 5'd0) && (op != SYSTEM);
        e.wb_sel = (op == LOAD) ? 2'd1 : (op == JAL || op == JALR) ? 2'd2 : (op == LUI) ? 2'd3 : 2'd0;
        e.pc_sel = (op == JAL) ? 2'd1 : (op == JALR) ? 2'd2 : 2'd0;
        emit(e);
        m_instret = m_instret + CW'(1);
    endtask

    task automatic play();
        cyc_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            @(posedge clk); #1;
            rst_n = e.rst_n; imem_ready = e.imem_ready; dmem_ready = e.dmem_ready;
            branch_taken = e.taken; opcode = e.op; funct3 = e.f3; rd = e.rd;
            cur = e; cur_valid = 1'b1;
        end
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cur_valid) begin
            chk("state_o",    32'(state_o),    32'(cur.state));
            chk("imem_req",   32'(imem_req),   32'(cur.imem_req));
            chk("ir_we",      32'(ir_we),      32'(cur.ir_we));
            chk("dmem_req",   32'(dmem_req),   32'(cur.dmem_req));
            chk("rf_we",      32'(rf_we),      32'(cur.rf_we));
            chk("pc_we",      32'(pc_we),      32'(cur.pc_we));
            chk("halted",     32'(halted),     32'(cur.halted));
            chk("trap",       32'(trap),       32'(cur.trap));
            chk("trap_cause", 32'(trap_cause), 32'(cur.cause));
            chk("instret",    32'(instret),    32'(cur.instret));
            if (cur.dmem_req) chk("dmem_we", 32'(dmem_we), 32'(cur.dmem_we));
            if (cur.state == 3'd2 || cur.state == 3'd3) begin
                chk("alu_src_a", 32'(alu_src_a), 32'(cur.src_a));
                chk("alu_src_b", 32'(alu_src_b), 32'(cur.src_b));
            end
            if (cur.rf_we) chk("wb_sel", 32'(wb_sel), 32'(cur.wb_sel));
            if (cur.pc_we) chk("pc_sel", 32'(pc_sel), 32'(cur.pc_sel));
        end
        if (!rst_n) dmem_cnt = 0;
        else if (dmem_req) dmem_cnt++;
    end

    initial begin
        int r, fw, mw;
        logic [6:0] op;
        logic [2:0] f3;
        logic [4:0] rdv;
        logic [6:0] legal_ops [10] = '{LOAD, STORE, OP, OPIM, BRANCH, JAL, JALR, LUI, AUIPC, SYSTEM};
        rst_n = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0; branch_taken = 1'b0;
        opcode = 7'd0; funct3 = 3'd0; rd = 5'd0;
        repeat (2) @(posedge clk);

        gen_reset(); gen_instr(OPIM, 3'd0, 5'd1, 0, 0, 1'b0); gen_fetch_idle(); play();
        @(negedge clk); #1;
        chk("pin_opim_instret", 32'(instret), 32'd1);

        gen_reset(); gen_instr(LOAD, 3'd2, 5'd5, 0, 3, 1'b0); gen_fetch_idle(); play();
        @(negedge clk); #1;
        chk("pin_load_instret", 32'(instret), 32'd1);
        chk("pin_load_dmem_cycles", 32'(dmem_cnt), 32'd4);

        gen_reset(); gen_instr(BRANCH, 3'd0, 5'd7, 0, 0, 1'b1);
        gen_instr(BRANCH, 3'd1, 5'd7, 1, 0, 1'b0); gen_fetch_idle(); play();
        @(negedge clk); #1;
        chk("pin_branch_instret", 32'(instret), 32'd2);

        gen_reset(); gen_instr(JAL, 3'd0, 5'd0, 0, 0, 1'b0);
        gen_instr(JALR, 3'd0, 5'd3, 2, 0, 1'b0); gen_fetch_idle(); play();
        @(negedge clk); #1;
        chk("pin_jal_jalr_instret", 32'(instret), 32'd2);

        gen_reset(); gen_instr(7'b0000000, 3'd0, 5'd1, 0, 0, 1'b0); play();
        @(negedge clk); #1;
        chk("pin_illegal_trap", 32'(trap), 32'd1);
        chk("pin_illegal_cause", 32'(trap_cause), 32'd1);
        chk("pin_illegal_pc_we", 32'(pc_we), 32'd0);

        gen_reset(); gen_instr(SYSTEM, 3'd0, 5'd0, 0, 0, 1'b0); play();
        @(negedge clk); #1;
        chk("pin_ecall_halted", 32'(halted), 32'd1);
        chk("pin_ecall_state", 32'(state_o), 32'd5);

        gen_reset(); gen_instr(STORE, 3'd2, 5'd0, 0, 100, 1'b0); play();
        @(negedge clk); #1;
        chk("pin_timeout_cause", 32'(trap_cause), 32'd2);
        chk("pin_timeout_dmem_cycles", 32'(dmem_cnt), 32'd16);

        gen_reset(); limit = n_emit + 6;
        gen_instr(STORE, 3'd2, 5'd0, 0, 100, 1'b0); gen_reset(); play();
        @(negedge clk); #1;
        chk("pin_midmem_reset_state", 32'(state_o), 32'd0);
        chk("pin_midmem_reset_instret", 32'(instret), 32'd0);
        chk("pin_midmem_reset_dmem_req", 32'(dmem_req), 32'd0);
        chk("pin_midmem_reset_imem_req", 32'(imem_req), 32'd0);

        gen_reset();
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            f3 = 3'($urandom);
            if (r < 4) begin
                do op = 7'($urandom); while (is_legal(op));
            end else if (r < 6) begin
                op = SYSTEM; f3 = 3'd0;
            end else begin
                op = legal_ops[$urandom_range(0, 9)];
                if (op == SYSTEM) f3 = 3'($urandom_range(1, 7));
            end
            rdv = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
            fw = ($urandom_range(0, 99) < 4) ? $urandom_range(13, 18) : $urandom_range(0, 3);
            mw = ($urandom_range(0, 99) < 4) ? $urandom_range(13, 18) : $urandom_range(0, 3);
            if ($urandom_range(0, 99) < 3) limit = n_emit + $urandom_range(1, 8);
            gen_instr(op, f3, rdv, fw, mw, 1'($urandom));
            if (m_halted || m_trap || n_emit >= limit) gen_reset();
            play();
        end

        @(negedge clk); #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
